// File: rtl/hex_page_sequencer_pkg.sv
// Shared types and constants for the hex page sequencer and its 7-segment page logic.
// Page select wraps modulo NUM_SLOTS.
package hex_page_sequencer_pkg;

    localparam int unsigned NUM_SLOTS    = 4;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned SEL_W        = 2;
    localparam int unsigned DEF_TICK_DIV = 50000000;
    localparam int unsigned DEF_CNT_W    = 26;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        FROZEN = 2'd2
    } seq_state_e;

    // Advance the page with natural 3 -> 0 wrap.
    function automatic logic [SEL_W-1:0] next_page(input logic [SEL_W-1:0] page);
        return page + SEL_W'(1);
    endfunction

endpackage

// File: rtl/hex_page_sequencer_if.sv
// Processor-side and display-side signals of the hex page sequencer.
// The slave modport is the sequencer; the master modport is whoever drives it.
interface hex_page_sequencer_if;
    import hex_page_sequencer_pkg::*;

    logic                  wr_en;
    logic [SEL_W-1:0]      wr_addr;
    logic [BYTE_W-1:0]     wr_data;
    logic                  auto_en;
    logic                  freeze;
    logic                  key_n;
    logic [BYTE_W-1:0]     byte0;
    logic [BYTE_W-1:0]     byte1;
    logic [BYTE_W-1:0]     byte2;
    logic [BYTE_W-1:0]     byte3;
    logic [SEL_W-1:0]      select;
    logic                  tick;
    logic                  page_changed;

    modport master (
        output wr_en, wr_addr, wr_data, auto_en, freeze, key_n,
        input  byte0, byte1, byte2, byte3, select, tick, page_changed
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, auto_en, freeze, key_n,
        output byte0, byte1, byte2, byte3, select, tick, page_changed
    );

endinterface

// File: rtl/hex_page_sequencer_key_edge_sync.sv
// Two-flop synchronizer plus falling-edge detector for an active-low board key.
// A key already held low when reset releases must be seen released before it can fire.
module key_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic fall_c_o
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic       armed_q;
    logic [1:0] vld_q;

    // vld_q[1] marks that sync_q holds a real post-reset sample rather than its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
            vld_q   <= 2'b00;
        end else begin
            meta_q <= key_n_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            vld_q  <= {vld_q[0], 1'b1};
            if (vld_q[1] && sync_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign fall_c_o = armed_q & prev_q & ~sync_q;

endmodule

// File: rtl/hex_page_sequencer.sv
// Byte bank and page-select sequencer feeding the two-digit selectable 7-segment decoder.
// Page advances on a prescaled tick (AUTO) or a key press (MANUAL); FROZEN holds everything.
module hex_page_sequencer
    import hex_page_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    hex_page_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    seq_state_e                       state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0][BYTE_W-1:0] bank_q, bank_d;
    logic [SEL_W-1:0]                 select_q, select_d;
    logic                             tick_q, tick_d;
    logic                             chg_q, chg_d;
    logic                             page_changed_q;
    logic                             step_c;
    logic                             advance_c;

    key_edge_sync u_key_edge_sync (
        .clk      (Clock),
        .rst_n    (Resetn),
        .key_n_i  (bus.key_n),
        .fall_c_o (step_c)
    );

    // Mode selection, prescaler, page advance and write bank next-state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bank_d    = bank_q;
        select_d  = select_q;
        advance_c = 1'b0;

        if (bus.freeze) begin
            state_d = FROZEN;
        end else if (bus.auto_en) begin
            state_d = AUTO;
        end else begin
            state_d = MANUAL;
        end

        unique case (state_q)
            AUTO: begin
                cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
                advance_c = tick_q;
            end
            FROZEN: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d     = '0;
                advance_c = step_c;
            end
        endcase

        if (advance_c) begin
            select_d = next_page(select_q);
        end

        if (bus.wr_en) begin
            bank_d[bus.wr_addr] = bus.wr_data;
        end

        // Tick is only raised for a cycle that will actually be spent in AUTO.
        tick_d = (state_d == AUTO) && (cnt_d == CNT_LAST);
        chg_d  = advance_c;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q        <= MANUAL;
            cnt_q          <= '0;
            bank_q         <= '0;
            select_q       <= '0;
            tick_q         <= 1'b0;
            chg_q          <= 1'b0;
            page_changed_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bank_q         <= bank_d;
            select_q       <= select_d;
            tick_q         <= tick_d;
            chg_q          <= chg_d;
            page_changed_q <= chg_q;
        end
    end

    assign bus.byte0        = bank_q[0];
    assign bus.byte1        = bank_q[1];
    assign bus.byte2        = bank_q[2];
    assign bus.byte3        = bank_q[3];
    assign bus.select       = select_q;
    assign bus.tick         = tick_q;
    assign bus.page_changed = page_changed_q;

endmodule

// File: tb/tb_hex_page_sequencer.sv
// Directed bench for hex_page_sequencer with a short prescaler (TICK_DIV=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_hex_page_sequencer;
    import hex_page_sequencer_pkg::*;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;

    always #5 Clock = ~Clock;

    hex_page_sequencer_if bus ();

    hex_page_sequencer #(
        .TICK_DIV (4),
        .CNT_W    (3)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [7:0]  eb [4];
    logic [7:0]  wv [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    function automatic logic [31:0] exp_bytes();
        return {eb[3], eb[2], eb[1], eb[0]};
    endfunction

    function automatic logic [31:0] got_bytes();
        return {bus.byte3, bus.byte2, bus.byte1, bus.byte0};
    endfunction

    // Hold the key low for 5 cycles: one step lands on the 3rd edge after the fall.
    task automatic press_step(input string tag, input logic [1:0] from);
        logic [1:0] nxt;
        nxt = from + 2'd1;
        bus.key_n = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc(1);
            chk({tag, "_sel"}, 32'(bus.select), 32'((k >= 3) ? nxt : from));
            chk({tag, "_pc"}, 32'(bus.page_changed), 32'(k == 4));
        end
        bus.key_n = 1'b1;
        cyc(4);
        chk({tag, "_hold"}, 32'(bus.select), 32'(nxt));
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = 2'd0;
        bus.wr_data = 8'h00;
        bus.auto_en = 1'b0;
        bus.freeze  = 1'b0;
        bus.key_n   = 1'b1;
        for (int i = 0; i < 4; i++) eb[i] = 8'h00;
        wv[0] = 8'h12; wv[1] = 8'h34; wv[2] = 8'h56; wv[3] = 8'h78;

        cyc(2);
        chk("rst_bytes", got_bytes(), 32'h0);
        chk("rst_sel", 32'(bus.select), 32'd0);
        chk("rst_tick", 32'(bus.tick), 32'd0);
        chk("rst_pc", 32'(bus.page_changed), 32'd0);
        Resetn = 1'b1;
        cyc(3);

        // Fill the bank on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 2'(i);
            bus.wr_data = wv[i];
            cyc(1);
            eb[i] = wv[i];
            chk("wr_bytes", got_bytes(), exp_bytes());
            chk("wr_sel", 32'(bus.select), 32'd0);
        end
        bus.wr_en = 1'b0;

        // Auto-advance from a cleared prescaler: tick on every 4th cycle.
        bus.auto_en = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            cyc(1);
            chk("auto_tick", 32'(bus.tick), 32'(c % 4 == 3));
            chk("auto_sel", 32'(bus.select), 32'((c / 4) % 4));
            chk("auto_pc", 32'(bus.page_changed), 32'((c >= 5) && (c % 4 == 1)));
        end

        bus.auto_en = 1'b0;
        cyc(3);
        chk("man_entry_sel", 32'(bus.select), 32'd0);

        press_step("key0", 2'd0);
        press_step("key1", 2'd1);
        press_step("key2", 2'd2);

        // Back to AUTO from select=3, then freeze with the prescaler at 2.
        bus.auto_en = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            cyc(1);
            chk("frz_pre_sel", 32'(bus.select), 32'((c < 4) ? 3 : 0));
            chk("frz_pre_tick", 32'(bus.tick), 32'(c == 3));
        end
        bus.freeze = 1'b1;
        cyc(1);
        chk("frz_sel", 32'(bus.select), 32'd0);
        bus.key_n = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            chk("frz_key_sel", 32'(bus.select), 32'd0);
            chk("frz_key_tick", 32'(bus.tick), 32'd0);
        end
        bus.key_n = 1'b1;
        cyc(4);
        chk("frz_rel_sel", 32'(bus.select), 32'd0);

        // Unfreeze: counter resumes from 2, so tick comes on the second edge.
        bus.freeze = 1'b0;
        cyc(1);
        chk("thaw1_tick", 32'(bus.tick), 32'd0);
        chk("thaw1_sel", 32'(bus.select), 32'd0);
        cyc(1);
        chk("thaw2_tick", 32'(bus.tick), 32'd1);
        chk("thaw2_sel", 32'(bus.select), 32'd0);
        cyc(1);
        chk("thaw3_tick", 32'(bus.tick), 32'd0);
        chk("thaw3_sel", 32'(bus.select), 32'd1);
        cyc(1);
        chk("thaw4_pc", 32'(bus.page_changed), 32'd1);
        chk("thaw4_sel", 32'(bus.select), 32'd1);
        cyc(1);
        chk("thaw5_pc", 32'(bus.page_changed), 32'd0);
        chk("thaw5_sel", 32'(bus.select), 32'd1);
        bus.auto_en = 1'b0;
        cyc(3);
        chk("thaw_man_sel", 32'(bus.select), 32'd1);

        // Step and write to the selected slot on the same edge.
        bus.key_n = 1'b0;
        cyc(1);
        chk("sim_e1_sel", 32'(bus.select), 32'd1);
        cyc(1);
        chk("sim_e2_sel", 32'(bus.select), 32'd1);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd1;
        bus.wr_data = 8'hC3;
        cyc(1);
        bus.wr_en = 1'b0;
        eb[1] = 8'hC3;
        chk("sim_sel", 32'(bus.select), 32'd2);
        chk("sim_bytes", got_bytes(), exp_bytes());
        cyc(2);
        bus.key_n = 1'b1;
        cyc(4);
        chk("sim_hold_sel", 32'(bus.select), 32'd2);

        // Mid-count reset with the key held low across release.
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd1;
        bus.wr_data = 8'hAB;
        cyc(1);
        bus.wr_en = 1'b0;
        eb[1] = 8'hAB;
        chk("pre_rst_bytes", got_bytes(), exp_bytes());
        chk("pre_rst_sel", 32'(bus.select), 32'd2);
        bus.auto_en = 1'b1;
        cyc(2);
        #2;
        bus.key_n = 1'b0;
        Resetn    = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) eb[i] = 8'h00;
        chk("arst_bytes", got_bytes(), exp_bytes());
        chk("arst_sel", 32'(bus.select), 32'd0);
        chk("arst_tick", 32'(bus.tick), 32'd0);
        chk("arst_pc", 32'(bus.page_changed), 32'd0);
        bus.auto_en = 1'b0;
        cyc(2);
        Resetn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            chk("held_key_sel", 32'(bus.select), 32'd0);
            chk("held_key_pc", 32'(bus.page_changed), 32'd0);
        end
        bus.key_n = 1'b1;
        cyc(4);
        press_step("post_rst", 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
